// File: rtl/control_pipeline.sv
// control_pipeline: hazard and sequencing controller for a 5-stage pipeline
// Inputs : clk, rst (async, active-high), ID source fields (id_rs, id_rt, id_usa_rt),
//          ID/EX load info (idex_memread, idex_rt), EX/MEM status (exmem_branch,
//          exmem_zf, exmem_memacc), data-memory handshake dm_ready.
// Outputs: PC and pipeline-buffer enables/flushes, dm_start pulse, sticky
//          timeout_err, saturating stall_cnt of cycles with pc_en=0.
module control_pipeline #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_usa_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zf,
  input  logic             exmem_memacc,
  input  logic             dm_ready,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             dm_start,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2;
  logic [1:0]    r_state;
  logic [WW-1:0] r_wcnt;
  logic [WW-1:0] w_wnx;
  logic          w_lu, w_br, w_run, w_wait, w_go, w_act, w_b, w_l;
  assign w_lu   = idex_memread && idex_rt != 5'd0 &&
                  (idex_rt == id_rs || (id_usa_rt && idex_rt == id_rt));
  assign w_br   = exmem_branch & exmem_zf;
  assign w_run  = r_state == S_RUN;
  assign w_wait = r_state == S_WAIT;
  assign w_go   = w_run & exmem_memacc;
  // w_act: the normal RUN decode applies (plain RUN, or WAIT_MEM completing)
  assign w_act  = !rst & ((w_run & !exmem_memacc) | (w_wait & dm_ready));
  assign w_b    = w_act & w_br;
  assign w_l    = w_act & !w_br & w_lu;
  assign w_wnx  = r_wcnt + WW'(1);
  assign pc_en       = w_act & !w_l;
  assign ifid_en     = w_act & !w_l;
  assign idex_en     = w_act;
  assign exmem_en    = w_act;
  assign memwb_en    = w_act;
  assign pc_sel      = w_b;
  assign ifid_flush  = w_b;
  assign idex_flush  = w_b | w_l;
  assign exmem_flush = w_b;
  assign dm_start    = !rst & w_go;
  assign timeout_err = r_state == S_ERR;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= S_RUN;
      r_wcnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (w_go) begin
        r_state <= S_WAIT;
        r_wcnt  <= '0;
      end else if (w_wait) begin
        r_state <= dm_ready ? S_RUN : (w_wnx == WW'(MEM_TIMEOUT)) ? S_ERR : S_WAIT;
        if (!dm_ready) r_wcnt <= w_wnx;
      end else if (r_state != S_ERR) r_state <= S_RUN;
      if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_control_pipeline.sv
// tb_control_pipeline: table vectors, corner sequences and random stimulus vs a reference model
module tb_control_pipeline;
  localparam logic [10:0] ZERO = 11'b00000000000;
  localparam logic [10:0] NRM  = 11'b10101010100;
  localparam logic [10:0] LU   = 11'b00001110100;
  localparam logic [10:0] BR   = 11'b11111111100;
  localparam logic [10:0] STR  = 11'b00000000010;
  localparam logic [10:0] ERR  = 11'b00000000001;
  localparam int TMO = 4;
  logic clk = 0, rst = 1;
  logic [4:0] id_rs = 0, id_rt = 0, idex_rt = 0;
  logic id_usa_rt = 0, idex_memread = 0, exmem_branch = 0, exmem_zf = 0, exmem_memacc = 0, dm_ready = 0;
  logic pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, dm_start, timeout_err;
  logic pc_en_s, pc_sel_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s, exmem_en_s, exmem_flush_s, memwb_en_s, dm_start_s, timeout_err_s;
  logic [15:0] stall_cnt;
  logic [2:0] stall_cnt_s;
  logic [10:0] o0, o1;
  always #5 clk = ~clk;
  control_pipeline #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_usa_rt(id_usa_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .exmem_branch(exmem_branch),
    .exmem_zf(exmem_zf), .exmem_memacc(exmem_memacc), .dm_ready(dm_ready),
    .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .dm_start(dm_start), .timeout_err(timeout_err), .stall_cnt(stall_cnt));
  control_pipeline #(.MEM_TIMEOUT(TMO), .CNT_W(3)) sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_usa_rt(id_usa_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .exmem_branch(exmem_branch),
    .exmem_zf(exmem_zf), .exmem_memacc(exmem_memacc), .dm_ready(dm_ready),
    .pc_en(pc_en_s), .pc_sel(pc_sel_s), .ifid_en(ifid_en_s), .ifid_flush(ifid_flush_s),
    .idex_en(idex_en_s), .idex_flush(idex_flush_s), .exmem_en(exmem_en_s), .exmem_flush(exmem_flush_s),
    .memwb_en(memwb_en_s), .dm_start(dm_start_s), .timeout_err(timeout_err_s), .stall_cnt(stall_cnt_s));
  assign o0 = {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, dm_start, timeout_err};
  assign o1 = {pc_en_s, pc_sel_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s, exmem_en_s, exmem_flush_s, memwb_en_s, dm_start_s, timeout_err_s};
  int n_vec = 0, n_bad = 0;
  int m_mode = 0, m_wait = 0, m_stalls = 0;
  typedef struct {
    string nm;
    logic [4:0] rs, rt, irt;
    logic usa, mr, br, zf, ma, rdy;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // mode 0 = running, 1 = waiting on memory, 2 = timed out
  function automatic logic [10:0] model();
    logic lu;
    lu = idex_memread && idex_rt != 0 && (idex_rt == id_rs || (id_usa_rt && idex_rt == id_rt));
    if (rst) return ZERO;
    if (m_mode == 2) return ERR;
    if (m_mode == 0 && exmem_memacc) return STR;
    if (m_mode == 1 && !dm_ready) return ZERO;
    if (exmem_branch && exmem_zf) return BR;
    if (lu) return LU;
    return NRM;
  endfunction
  task automatic setin(input logic [4:0] rs, input logic [4:0] rt, input logic usa, input logic mr,
                       input logic [4:0] irt, input logic br, input logic zf, input logic ma, input logic rdy);
    id_rs = rs; id_rt = rt; id_usa_rt = usa; idex_memread = mr; idex_rt = irt;
    exmem_branch = br; exmem_zf = zf; exmem_memacc = ma; dm_ready = rdy;
  endtask
  task automatic cyc(input string nm);
    logic [10:0] e;
    #1;
    if (rst) begin m_mode = 0; m_wait = 0; m_stalls = 0; end
    e = model();
    chk({nm, " outs"}, 32'(o0), 32'(e));
    chk({nm, " outs_w3"}, 32'(o1), 32'(e));
    chk({nm, " stall_cnt"}, 32'(stall_cnt), m_stalls > 65535 ? 65535 : m_stalls);
    chk({nm, " stall_cnt_w3"}, 32'(stall_cnt_s), m_stalls > 7 ? 7 : m_stalls);
    @(posedge clk);
    if (!rst) begin
      if (!e[10]) m_stalls++;
      if (m_mode == 0 && exmem_memacc) begin m_mode = 1; m_wait = 0; end
      else if (m_mode == 1) begin
        if (dm_ready) m_mode = 0;
        else begin m_wait++; if (m_wait == TMO) m_mode = 2; end
      end
    end
    @(negedge clk);
  endtask
  task automatic async_rst(input string nm);
    #2 rst = 1;
    #1;
    chk({nm, " outs"}, 32'(o0), 32'(ZERO));
    chk({nm, " stall_cnt"}, 32'(stall_cnt), 0);
    chk({nm, " stall_cnt_w3"}, 32'(stall_cnt_s), 0);
    chk({nm, " timeout_err"}, 32'(timeout_err), 0);
    m_mode = 0; m_wait = 0; m_stalls = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask
  task automatic add(input string nm, input logic [4:0] rs, input logic [4:0] rt, input logic usa,
                     input logic mr, input logic [4:0] irt, input logic br, input logic zf,
                     input logic ma, input logic rdy, input logic [10:0] exp);
    vec_t v;
    v.nm = nm; v.rs = rs; v.rt = rt; v.usa = usa; v.mr = mr; v.irt = irt;
    v.br = br; v.zf = zf; v.ma = ma; v.rdy = rdy; v.exp = exp;
    tbl.push_back(v);
  endtask
  initial begin
    int starts, zcyc;
    add("lu_rs",      5, 0, 0, 1, 5, 0, 0, 0, 0, LU);
    add("lu_r0",      0, 0, 1, 1, 0, 0, 0, 0, 0, NRM);
    add("lu_rt",      1, 7, 1, 1, 7, 0, 0, 0, 0, LU);
    add("lu_rt_nouse",1, 7, 0, 1, 7, 0, 0, 0, 0, NRM);
    add("no_load",    5, 0, 0, 0, 5, 0, 0, 0, 0, NRM);
    add("br_taken",   0, 0, 0, 0, 0, 1, 1, 0, 0, BR);
    add("br_nottaken",0, 0, 0, 0, 0, 1, 0, 0, 0, NRM);
    add("br_over_lu", 5, 0, 0, 1, 5, 1, 1, 0, 0, BR);
    add("mem_over_lu",5, 0, 0, 1, 5, 0, 0, 1, 0, STR);
    add("wait_mem",   5, 0, 0, 1, 5, 0, 0, 1, 0, ZERO);
    add("ready_lu",   5, 0, 0, 1, 5, 0, 0, 1, 1, LU);
    add("stray_ready",0, 0, 0, 0, 0, 0, 0, 0, 1, NRM);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset outs", 32'(o0), 32'(ZERO));
    chk("reset stall_cnt", 32'(stall_cnt), 0);
    #1 rst = 0;
    @(negedge clk);
    foreach (tbl[i]) begin
      setin(tbl[i].rs, tbl[i].rt, tbl[i].usa, tbl[i].mr, tbl[i].irt, tbl[i].br, tbl[i].zf, tbl[i].ma, tbl[i].rdy);
      #1 chk({tbl[i].nm, " table"}, 32'(o0), 32'(tbl[i].exp));
      cyc(tbl[i].nm);
    end
    chk("table stall total", 32'(stall_cnt), 5);
    // memory access, ready three cycles after the start
    starts = 0; zcyc = 0;
    for (int k = 0; k < 4; k++) begin
      setin(0, 0, 0, 0, 0, 0, 0, 1, k == 3);
      #1 starts += dm_start; zcyc += !(pc_en | ifid_en | idex_en | exmem_en | memwb_en);
      cyc("mem3");
    end
    chk("mem3 dm_start pulses", starts, 1);
    chk("mem3 stalled cycles", zcyc, 3);
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("mem3 back to run", 32'(o0), 32'(NRM));
    cyc("mem3_after");
    // timeout: no ready for TMO wait cycles
    for (int k = 0; k <= TMO; k++) begin
      setin(0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("tmo");
    end
    #1 chk("tmo error", 32'(o0), 32'(ERR));
    setin(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("tmo_ready");
    #1 chk("tmo sticky", 32'(timeout_err), 1);
    for (int k = 0; k < 10; k++) cyc("tmo_hold");
    chk("stall_cnt saturated w3", 32'(stall_cnt_s), 7);
    async_rst("rst_in_error");
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("after rst_in_error", 32'(o0), 32'(NRM));
    cyc("after_rst_err");
    setin(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("w_start");
    cyc("w_wait");
    async_rst("rst_in_wait");
    setin(5, 0, 0, 1, 5, 0, 0, 0, 0);
    #1 chk("after rst_in_wait", 32'(o0), 32'(LU));
    cyc("after_rst_wait");
    for (int k = 0; k < 3000; k++) begin
      rst = $urandom_range(99) < 2;
      setin(5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom), 1'($urandom),
            5'($urandom_range(3)), 1'($urandom), 1'($urandom),
            $urandom_range(99) < 15, $urandom_range(99) < 40);
      cyc("rand");
    end
    rst = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
